beamscaler_reader: RTL and testbench



---
 rtl/beamscaler_pkg.sv | 29 ++
 rtl/beamscaler_reader_fifo.sv | 55 +++++
 rtl/beamscaler_reader.sv | 182 ++++++++++++++++++
 tb/tb_beamscaler_reader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamscaler_pkg.sv
// Shared types and constants for the beam scaler read-side sequencer.
package beamscaler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_READ   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic [7:0] HDR_TAG_DEFAULT = 8'hB5;
    localparam int         RD_LATENCY      = 2;

    // Header word: {tag, seq, missed, bank, 3'b000, word count}
    localparam int HDR_TAG_LSB    = 24;
    localparam int HDR_TAG_W      = 8;
    localparam int HDR_SEQ_LSB    = 16;
    localparam int HDR_SEQ_W      = 8;
    localparam int HDR_MISSED_LSB = 12;
    localparam int HDR_MISSED_W   = 4;
    localparam int HDR_BANK_BIT   = 11;
    localparam int HDR_COUNT_LSB  = 0;
    localparam int HDR_COUNT_W    = 8;

    function automatic int ndualbeams(input int nbeams);
        return nbeams / 2 + nbeams % 2;
    endfunction

endpackage

// File: rtl/beamscaler_reader_fifo.sv
// First-word-fall-through output buffer; the fill count feeds the read credit check.
module beamscaler_reader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/beamscaler_reader.sv
// Reads one packet of dual-beam words per scaler update and streams it with a header.
// Optional saturation flagging of body words: BEAMSCALER_READER_SATFLAG_EN.
module beamscaler_reader
    import beamscaler_pkg::*;
#(
    parameter int         NBEAMS     = 2,
    parameter logic [7:0] HDR_TAG    = HDR_TAG_DEFAULT,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        done_i,
    input  logic        write_bank_i,
    output logic        scal_rd_o,
    output logic [6:0]  scal_adr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam int         NDB       = ndualbeams(NBEAMS);
    localparam logic [6:0] LAST_ADR  = 7'(NDB - 1);
    localparam logic [7:0] NDB_FIELD = (NDB == 128) ? 8'd0 : 8'(NDB);
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic                  bank_q, bank_d;
    logic [6:0]            adr_q, adr_d;
    logic [7:0]            seq_q;
    logic [3:0]            missed_q;
    logic                  overrun_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] last_q;

    logic                  hdr_push;
    logic                  rd;
    logic                  overrun_d;
    logic                  credit_ok;
    logic [CW:0]           occupancy;
    logic [31:0]           header;
    logic [31:0]           body;
    logic                  fifo_push;
    logic [32:0]           fifo_wdata;
    logic [32:0]           fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;

    // Words already buffered plus reads still in the RAM pipeline must fit.
    always_comb begin
        occupancy = (CW + 1)'(fifo_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occupancy = occupancy + (CW + 1)'(vld_q[i]);
        end
        credit_ok = occupancy < (CW + 1)'(FIFO_DEPTH);
    end

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        adr_d    = adr_q;
        hdr_push = 1'b0;
        rd       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (done_i) begin
                    bank_d  = write_bank_i;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!fifo_full) begin
                    hdr_push = 1'b1;
                    adr_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    rd = 1'b1;
                    if (adr_q == LAST_ADR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        adr_d = adr_q + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overrun_d = done_i && (state_q != ST_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            bank_q    <= 1'b0;
            adr_q     <= '0;
            seq_q     <= '0;
            missed_q  <= '0;
            overrun_q <= 1'b0;
            vld_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            adr_q     <= adr_d;
            overrun_q <= overrun_d;
            vld_q     <= {vld_q[RD_LATENCY-2:0], rd};
            last_q    <= {last_q[RD_LATENCY-2:0], rd && (adr_q == LAST_ADR)};
            if (hdr_push) begin
                seq_q <= seq_q + 8'd1;
            end
            // An overrun coinciding with the header push belongs to the next packet.
            if (hdr_push) begin
                missed_q <= overrun_d ? 4'd1 : 4'd0;
            end else if (overrun_d && (missed_q != 4'hF)) begin
                missed_q <= missed_q + 4'd1;
            end
        end
    end

    always_comb begin
        header = '0;
        header[HDR_TAG_LSB    +: HDR_TAG_W]    = HDR_TAG;
        header[HDR_SEQ_LSB    +: HDR_SEQ_W]    = seq_q;
        header[HDR_MISSED_LSB +: HDR_MISSED_W] = missed_q;
        header[HDR_BANK_BIT]                   = bank_q;
        header[HDR_COUNT_LSB  +: HDR_COUNT_W]  = NDB_FIELD;
    end

`ifdef BEAMSCALER_READER_SATFLAG_EN
    always_comb begin
        body = scal_dat_i;
        if (scal_dat_i[11:0] == 12'hFFF) begin
            body[15] = 1'b1;
        end
        if (scal_dat_i[27:16] == 12'hFFF) begin
            body[31] = 1'b1;
        end
    end
`else
    assign body = scal_dat_i;
`endif

    // Header and body pushes never coincide: the header is pushed with no reads in flight.
    assign fifo_push  = hdr_push || vld_q[RD_LATENCY-1];
    assign fifo_wdata = hdr_push ? {1'b0, header} : {last_q[RD_LATENCY-1], body};

    beamscaler_reader_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .srst_i      (wb_rst_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (m_tvalid && m_tready),
        .data_o      (fifo_rdata),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign m_tvalid   = !fifo_empty;
    assign m_tdata    = fifo_rdata[31:0];
    assign m_tlast    = fifo_rdata[32] && !fifo_empty;
    assign scal_rd_o  = rd;
    assign scal_adr_o = adr_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = (state_q != ST_IDLE) && !((state_q == ST_DRAIN) && (vld_q == '0));

endmodule

// File: tb/tb_beamscaler_reader.sv
// Scoreboard bench for beamscaler_reader (NBEAMS=8, four body words per packet).
module tb_beamscaler_reader;

    localparam int NBEAMS = 8;
    localparam int NDB    = 4;
    localparam int DEPTH  = 4;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        done_i;
    logic        write_bank_i;
    logic        scal_rd_o;
    logic [6:0]  scal_adr_o;
    logic [31:0] scal_dat_i;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        overrun_o;
    logic        busy_o;

    beamscaler_reader #(
        .NBEAMS     (NBEAMS),
        .HDR_TAG    (8'hB5),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .done_i       (done_i),
        .write_bank_i (write_bank_i),
        .scal_rd_o    (scal_rd_o),
        .scal_adr_o   (scal_adr_o),
        .scal_dat_i   (scal_dat_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // RAM model: data for the address presented with scal_rd_o appears two cycles later.
    logic [31:0] ram_base;
    logic [6:0]  adr_d1;
    always @(posedge wb_clk_i) begin
        adr_d1     <= scal_adr_o;
        scal_dat_i <= ram_base + {25'd0, adr_d1};
    end

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    logic [7:0]  seq_m;
    logic [3:0]  missed_m;
    int          rd_total;
    int          hdr_total;
    int          pop_total;
    int          ovr_seen;
    logic        stall_prev;
    logic [32:0] stall_word;

    function automatic logic [31:0] body_word(input int a);
        logic [31:0] w;
        w = ram_base + 32'(a);
`ifdef BEAMSCALER_READER_SATFLAG_EN
        if (w[11:0] == 12'hFFF) w[15] = 1'b1;
        if (w[27:16] == 12'hFFF) w[31] = 1'b1;
`endif
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        seq_m      = 8'd0;
        missed_m   = 4'd0;
        rd_total   = 0;
        hdr_total  = 0;
        pop_total  = 0;
        stall_prev = 1'b0;
    endtask

    // One clock: sample DUT at the falling edge, score beats, then drive inputs.
    task automatic tick(input logic rdy, input logic dn);
        logic [32:0] e;
        @(negedge wb_clk_i);
        m_tready = rdy;
        done_i   = dn;
        if (stall_prev) begin
            n_checks++;
            if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== stall_word)
                $display("FAIL stall_hold: got valid=%b word=%h, expected valid=1 word=%h",
                         m_tvalid, {m_tlast, m_tdata}, stall_word);
            else n_pass++;
        end
        if (scal_rd_o === 1'b1) begin
            n_checks++;
            if (rd_total + hdr_total - pop_total >= DEPTH)
                $display("FAIL credit: read issued with occupancy %0d, expected < %0d",
                         rd_total + hdr_total - pop_total, DEPTH);
            else n_pass++;
            rd_total++;
        end
        if (m_tvalid === 1'b1 && rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat: got unexpected beat %h, expected none", {m_tlast, m_tdata});
            end else begin
                e = exp_q.pop_front();
                if ({m_tlast, m_tdata} !== e)
                    $display("FAIL beat: got last=%b data=%h, expected last=%b data=%h",
                             m_tlast, m_tdata, e[32], e[31:0]);
                else n_pass++;
            end
            pop_total++;
        end
        if (overrun_o === 1'b1) ovr_seen++;
        stall_prev = (m_tvalid === 1'b1) && !rdy;
        stall_word = {m_tlast, m_tdata};
    endtask

    task automatic start_packet(input logic bank, input logic rdy);
        write_bank_i = bank;
        exp_q.push_back({1'b0, 8'hB5, seq_m, missed_m, bank, 3'b000, 8'(NDB)});
        for (int a = 0; a < NDB; a++) exp_q.push_back({(a == NDB - 1), body_word(a)});
        seq_m     = seq_m + 8'd1;
        missed_m  = 4'd0;
        hdr_total++;
        tick(rdy, 1'b1);
    endtask

    task automatic overrun_pulse(input logic rdy);
        if (missed_m != 4'hF) missed_m = missed_m + 4'd1;
        tick(rdy, 1'b1);
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            tick(1'b1, 1'b0);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
        else n_pass++;
        repeat (3) tick(1'b1, 1'b0);
        n_checks++;
        if (busy_o !== 1'b0 || m_tvalid !== 1'b0)
            $display("FAIL idle_after_packet: got busy=%b valid=%b, expected 0 0", busy_o, m_tvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        done_i = 1'b0;
        m_tready = 1'b0;
        write_bank_i = 1'b0;
        ram_base = 32'd0;
        ovr_seen = 0;
        model_clear();
        repeat (3) @(negedge wb_clk_i);
        n_checks++;
        if ({scal_rd_o, scal_adr_o, m_tvalid, m_tlast, overrun_o, busy_o} !== 12'd0)
            $display("FAIL reset_outputs: got rd=%b adr=%h valid=%b last=%b ovr=%b busy=%b, expected all 0",
                     scal_rd_o, scal_adr_o, m_tvalid, m_tlast, overrun_o, busy_o);
        else n_pass++;
        wb_rst_i = 1'b0;
        repeat (2) tick(1'b1, 1'b0);
        n_checks++;
        if (busy_o !== 1'b0 || m_tvalid !== 1'b0 || scal_rd_o !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b valid=%b rd=%b, expected 0 0 0",
                     busy_o, m_tvalid, scal_rd_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic busy_prev;
        bit   seen_last;
        ram_base = 32'h0ABC_0123;
        start_packet(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        n_checks++;
        if (busy_o !== 1'b1 || m_tvalid !== 1'b0)
            $display("FAIL hdr_latency_c1: got busy=%b valid=%b, expected 1 0", busy_o, m_tvalid);
        else n_pass++;
        tick(1'b1, 1'b0);
        n_checks++;
        if (m_tvalid !== 1'b1 || scal_rd_o !== 1'b1)
            $display("FAIL hdr_latency_c2: got valid=%b rd=%b, expected 1 1", m_tvalid, scal_rd_o);
        else n_pass++;
        repeat (2) tick(1'b1, 1'b0);
        n_checks++;
        if (m_tvalid !== 1'b0)
            $display("FAIL body_gap_c4: got valid=%b, expected 0", m_tvalid);
        else n_pass++;
        tick(1'b1, 1'b0);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h0ABC_0123)
            $display("FAIL body_latency_c5: got valid=%b data=%h, expected 1 0abc0123", m_tvalid, m_tdata);
        else n_pass++;
        busy_prev = busy_o;
        seen_last = 1'b0;
        for (int i = 0; i < 20 && !seen_last; i++) begin
            tick(1'b1, 1'b0);
            if (m_tvalid === 1'b1 && m_tlast === 1'b1) begin
                seen_last = 1'b1;
                n_checks++;
                if (busy_o !== 1'b0 || busy_prev !== 1'b1)
                    $display("FAIL busy_fall: got busy_prev=%b busy=%b, expected 1 0", busy_prev, busy_o);
                else n_pass++;
            end
            busy_prev = busy_o;
        end
        n_checks++;
        if (!seen_last) $display("FAIL tlast_seen: got no tlast beat, expected one");
        else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        ram_base = 32'h0055_0AA0;
        start_packet(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick(i[0], 1'b0);
        drain();
    endtask

    task automatic test_overrun();
        ram_base = 32'h0ABC_0123;
        ovr_seen = 0;
        start_packet(1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        n_checks++;
        if (busy_o !== 1'b1)
            $display("FAIL overrun_in_read: got busy=%b, expected 1", busy_o);
        else n_pass++;
        overrun_pulse(1'b1);
        drain();
        n_checks++;
        if (ovr_seen != 1)
            $display("FAIL overrun_pulses: got %0d, expected 1", ovr_seen);
        else n_pass++;
        start_packet(1'b0, 1'b1);
        drain();
    endtask

    task automatic test_saturate();
        ram_base = 32'h0100_0200;
        ovr_seen = 0;
        start_packet(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            overrun_pulse(1'b0);
            tick(1'b0, 1'b0);
        end
        drain();
        n_checks++;
        if (ovr_seen != 20)
            $display("FAIL overrun_count: got %0d, expected 20", ovr_seen);
        else n_pass++;
        start_packet(1'b1, 1'b1);
        drain();
        start_packet(1'b0, 1'b1);
        drain();
    endtask

    task automatic test_satflag();
        logic [31:0] want;
`ifdef BEAMSCALER_READER_SATFLAG_EN
        want = 32'h8FFF_0FFE;
`else
        want = 32'h0FFF_0FFE;
`endif
        ram_base = 32'h0FFF_0FFE;
        start_packet(1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b0);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== want)
            $display("FAIL satflag_body: got valid=%b data=%h, expected 1 %h", m_tvalid, m_tdata, want);
        else n_pass++;
        drain();
    endtask

    task automatic test_seq_wrap();
        ram_base = 32'h0000_0010;
        for (int p = 0; p < 256; p++) begin
            start_packet(p[0], 1'b1);
            drain();
        end
    endtask

    task automatic test_reset_midpacket();
        ram_base = 32'h0123_0456;
        start_packet(1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        wb_rst_i = 1'b1;
        model_clear();
        tick(1'b0, 1'b0);
        n_checks++;
        if (m_tvalid !== 1'b0 || scal_rd_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL reset_midpacket: got valid=%b rd=%b busy=%b, expected 0 0 0",
                     m_tvalid, scal_rd_o, busy_o);
        else n_pass++;
        wb_rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (m_tvalid !== 1'b0)
                $display("FAIL late_data_dropped: got valid=%b, expected 0", m_tvalid);
            else n_pass++;
        end
        start_packet(1'b1, 1'b1);
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_saturate();
        test_satflag();
        test_seq_wrap();
        test_reset_midpacket();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
